// File: rtl/dual_port_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_ram_arbiter_pkg
//  Description : Shared definitions for the dual-port RAM arbiter: requester
//                id width helper and the values driven onto an idle RAM port.
//  Revision    : 1.0 - initial release
// ============================================================================
package dual_port_ram_arbiter_pkg;

    // Value placed on the write-enable of a RAM port that serves nobody.
    // Address and write data of an idle port are driven to all-zero.
    localparam logic IDLE_WE = 1'b0;

    // Number of bits needed to hold a requester index 0..n-1 (at least 1).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : dual_port_ram_arbiter_pkg
`default_nettype wire

// File: rtl/dual_port_ram_arbiter_rr_two_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_two_pick
//  Description : Purely combinational round-robin selector that picks up to
//                two requesters per cycle, starting the scan at rr_ptr_i.
//                The first requester found goes to port 0; the next one goes
//                to port 1 unless the pair is marked as conflicting.
//  Ports       : req_i       - request valid per requester
//                rr_ptr_i    - requester index where the scan starts
//                conflict_i  - row-major NUM_REQ x NUM_REQ matrix; bit
//                              [a*NUM_REQ+b] set means a and b must not be
//                              served together
//                p0_valid_o/p0_id_o - port 0 selection
//                p1_valid_o/p1_id_o - port 1 selection
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_two_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [ID_W-1:0]            rr_ptr_i,
    input  logic [NUM_REQ*NUM_REQ-1:0] conflict_i,
    output logic                       p0_valid_o,
    output logic [ID_W-1:0]            p0_id_o,
    output logic                       p1_valid_o,
    output logic [ID_W-1:0]            p1_id_o
);

    logic [ID_W:0]    sum;
    logic [ID_W-1:0]  idx;
    logic             p0_found;
    logic [ID_W-1:0]  p0_id;
    logic             p1_found;
    logic [ID_W-1:0]  p1_id;
    logic [NUM_REQ-1:0] conf_row;

    always_comb begin
        sum      = '0;
        idx      = '0;
        p0_found = 1'b0;
        p0_id    = '0;
        p1_found = 1'b0;
        p1_id    = '0;
        conf_row = '0;

        // Walk rr_ptr, rr_ptr+1, ... modulo NUM_REQ; one extra bit on the
        // sum keeps the wrap correct for non-power-of-two NUM_REQ.
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_i} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req_i[idx]) begin
                if (!p0_found) begin
                    p0_found = 1'b1;
                    p0_id    = idx;
                end else if (!p1_found) begin
                    p1_found = 1'b1;
                    p1_id    = idx;
                end
            end
        end

        // Only the second candidate is ever examined; a conflicting pair
        // leaves port 1 idle rather than searching for a third requester.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (p0_id == ID_W'(j)) begin
                conf_row = conflict_i[j*NUM_REQ +: NUM_REQ];
            end
        end

        p0_valid_o = p0_found;
        p0_id_o    = p0_id;
        p1_valid_o = p1_found && !conf_row[p1_id];
        p1_id_o    = p1_id;
    end

endmodule : rr_two_pick
`default_nettype wire

// File: rtl/dual_port_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dual_port_ram_arbiter
//  Description : Shares one dual-port RAM among NUM_REQ requesters. Up to two
//                requests are granted per cycle in round-robin order, pairs
//                touching the same address with a write are split across
//                cycles, and the RAM's registered read data is routed back to
//                the issuing requester one cycle after grant.
//  Ports       : clock, reset           - clock, synchronous active-high reset
//                req/req_we/req_address/req_data - flattened requester inputs
//                grant                  - combinational accept per requester
//                resp_valid/resp_data   - response one cycle after grant
//                ram_*0 / ram_*1        - RAM port 0 / port 1 connections
//  Revision    : 1.0 - initial release
// ============================================================================
module dual_port_ram_arbiter
    import dual_port_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int NUM_REQ       = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               resp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    resp_data,
    output logic                             ram_we0,
    output logic                             ram_we1,
    output logic [ADDRESS_WIDTH-1:0]         ram_address0,
    output logic [ADDRESS_WIDTH-1:0]         ram_address1,
    output logic [DATA_WIDTH-1:0]            ram_data_in0,
    output logic [DATA_WIDTH-1:0]            ram_data_in1,
    input  logic [DATA_WIDTH-1:0]            ram_data_out0,
    input  logic [DATA_WIDTH-1:0]            ram_data_out1
);

    localparam int ID_W = id_width(NUM_REQ);

    // ------------------------------------------------------------------
    // Pairwise conflict matrix: same full address and at least one write.
    // Computed for every pair so it does not depend on the port 0 choice.
    // ------------------------------------------------------------------
    logic [NUM_REQ*NUM_REQ-1:0] conflict;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_conf_row
            for (genvar gj = 0; gj < NUM_REQ; gj++) begin : g_conf_col
                assign conflict[gi*NUM_REQ+gj] =
                    (req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH] ==
                     req_address[gj*ADDRESS_WIDTH +: ADDRESS_WIDTH]) &&
                    (req_we[gi] || req_we[gj]);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            p0_valid, p1_valid;
    logic [ID_W-1:0] p0_id, p1_id;

    rr_two_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i      (req),
        .rr_ptr_i   (rr_ptr_q),
        .conflict_i (conflict),
        .p0_valid_o (p0_valid),
        .p0_id_o    (p0_id),
        .p1_valid_o (p1_valid),
        .p1_id_o    (p1_id)
    );

    // Nothing is granted while reset is high, so the RAM never sees a write.
    logic p0_go, p1_go;
    assign p0_go = p0_valid && !reset;
    assign p1_go = p1_valid && !reset;

    // ------------------------------------------------------------------
    // Grant vector and RAM port muxes
    // ------------------------------------------------------------------
    always_comb begin
        grant        = '0;
        ram_we0      = IDLE_WE;
        ram_address0 = '0;
        ram_data_in0 = '0;
        ram_we1      = IDLE_WE;
        ram_address1 = '0;
        ram_data_in1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (p0_go && (p0_id == ID_W'(i))) begin
                grant[i]     = 1'b1;
                ram_we0      = req_we[i];
                ram_address0 = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                ram_data_in0 = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (p1_go && (p1_id == ID_W'(i))) begin
                grant[i]     = 1'b1;
                ram_we1      = req_we[i];
                ram_address1 = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                ram_data_in1 = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pointer: one past the last requester served this cycle
    // ------------------------------------------------------------------
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (p1_go) begin
            rr_ptr_d = (p1_id == ID_W'(NUM_REQ-1)) ? '0 : p1_id + 1'b1;
        end else if (p0_go) begin
            rr_ptr_d = (p0_id == ID_W'(NUM_REQ-1)) ? '0 : p0_id + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Port tracking: who each RAM port served, for the response next cycle
    // ------------------------------------------------------------------
    logic            port0_valid_q, port1_valid_q;
    logic [ID_W-1:0] port0_id_q, port1_id_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            port0_valid_q <= 1'b0;
            port1_valid_q <= 1'b0;
            port0_id_q    <= '0;
            port1_id_q    <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            port0_valid_q <= p0_go;
            port1_valid_q <= p1_go;
            port0_id_q    <= p0_id;
            port1_id_q    <= p1_id;
        end
    end

    // ------------------------------------------------------------------
    // Response demux. Gating with reset drops a response whose grant was
    // captured just before reset rose.
    // ------------------------------------------------------------------
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!reset && port0_valid_q && (port0_id_q == ID_W'(i))) begin
                resp_valid[i]                         = 1'b1;
                resp_data[i*DATA_WIDTH +: DATA_WIDTH] = ram_data_out0;
            end
            if (!reset && port1_valid_q && (port1_id_q == ID_W'(i))) begin
                resp_valid[i]                         = 1'b1;
                resp_data[i*DATA_WIDTH +: DATA_WIDTH] = ram_data_out1;
            end
        end
    end

endmodule : dual_port_ram_arbiter
`default_nettype wire

// File: tb/tb_dual_port_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_port_ram_arbiter
//  Description : Self-checking bench for dual_port_ram_arbiter with a small
//                write-first RAM and a behavioural model of arbitration,
//                memory contents and responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_address;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      grant;
    logic [N-1:0]      resp_valid;
    logic [N*DW-1:0]   resp_data;
    logic              ram_we0, ram_we1;
    logic [AW-1:0]     ram_address0, ram_address1;
    logic [DW-1:0]     ram_data_in0, ram_data_in1;
    logic [DW-1:0]     ram_data_out0, ram_data_out1;

    dual_port_ram_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .NUM_REQ       (N)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .req           (req),
        .req_we        (req_we),
        .req_address   (req_address),
        .req_data      (req_data),
        .grant         (grant),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .ram_we0       (ram_we0),
        .ram_we1       (ram_we1),
        .ram_address0  (ram_address0),
        .ram_address1  (ram_address1),
        .ram_data_in0  (ram_data_in0),
        .ram_data_in1  (ram_data_in1),
        .ram_data_out0 (ram_data_out0),
        .ram_data_out1 (ram_data_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first dual-port RAM, 16 words, registered read data.
    logic          ram_init;
    logic [DW-1:0] ram_mem [16];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 16; k++) ram_mem[k] <= 32'hA0 + k;
        end else begin
            if (ram_we0) ram_mem[ram_address0[3:0]] <= ram_data_in0;
            if (ram_we1) ram_mem[ram_address1[3:0]] <= ram_data_in1;
        end
        ram_data_out0 <= ram_we0 ? ram_data_in0 : ram_mem[ram_address0[3:0]];
        ram_data_out1 <= ram_we1 ? ram_data_in1 : ram_mem[ram_address1[3:0]];
    end

    // Reference model state
    int            checks;
    int            errors;
    int            m_rr;
    logic [DW-1:0] m_mem [16];
    bit            pend_v [N];
    logic [DW-1:0] pend_d [N];

    // Values captured at the last sampling point, for directed checks
    logic [N-1:0]    last_grant;
    logic            last_we0;
    logic            last_we_any;
    logic [N-1:0]    last_rv;
    logic [N*DW-1:0] last_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input bit we, input int addr, input logic [DW-1:0] d);
        req[r]                 = 1'b1;
        req_we[r]              = we;
        req_address[r*AW +: AW] = AW'(addr);
        req_data[r*DW +: DW]    = d;
    endtask

    function automatic logic [AW-1:0] addr_of(input int r);
        return req_address[r*AW +: AW];
    endfunction

    // Model the served request's effect on memory and its response value.
    task automatic serve(input int r);
        int a;
        a = int'(addr_of(r) & 32'hF);
        if (req_we[r]) begin
            m_mem[a]  = req_data[r*DW +: DW];
            pend_d[r] = req_data[r*DW +: DW];
        end else begin
            pend_d[r] = m_mem[a];
        end
        pend_v[r] = 1'b1;
    endtask

    // One clock cycle: entered 1 time unit after a rising edge with inputs
    // already applied; checks outputs mid-cycle, then advances the model.
    task automatic cycle();
        int            p0, p1, idx;
        logic [N-1:0]  eg;
        logic          ewe0, ewe1;
        logic [AW-1:0] ea0, ea1;
        logic [DW-1:0] ed0, ed1;
        bit            ev;

        #3;
        for (int i = 0; i < N; i++) begin
            ev = pend_v[i] && !reset;
            chk($sformatf("resp_valid[%0d]", i), 64'(resp_valid[i]), 64'(ev));
            if (ev) chk($sformatf("resp_data[%0d]", i), 64'(resp_data[i*DW +: DW]), 64'(pend_d[i]));
        end
        last_rv    = resp_valid;
        last_rdata = resp_data;

        p0 = -1;
        p1 = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (req[idx]) begin
                    if (p0 < 0) p0 = idx;
                    else if (p1 < 0) p1 = idx;
                end
            end
        end
        if (p1 >= 0 && addr_of(p0) == addr_of(p1) && (req_we[p0] || req_we[p1])) p1 = -1;

        eg   = '0;
        ewe0 = 1'b0; ea0 = '0; ed0 = '0;
        ewe1 = 1'b0; ea1 = '0; ed1 = '0;
        if (p0 >= 0) begin
            eg[p0] = 1'b1;
            ewe0 = req_we[p0]; ea0 = addr_of(p0); ed0 = req_data[p0*DW +: DW];
        end
        if (p1 >= 0) begin
            eg[p1] = 1'b1;
            ewe1 = req_we[p1]; ea1 = addr_of(p1); ed1 = req_data[p1*DW +: DW];
        end

        chk("grant", 64'(grant), 64'(eg));
        chk("ram_we0", 64'(ram_we0), 64'(ewe0));
        chk("ram_address0", 64'(ram_address0), 64'(ea0));
        chk("ram_data_in0", 64'(ram_data_in0), 64'(ed0));
        chk("ram_we1", 64'(ram_we1), 64'(ewe1));
        chk("ram_address1", 64'(ram_address1), 64'(ea1));
        chk("ram_data_in1", 64'(ram_data_in1), 64'(ed1));
        last_grant  = grant;
        last_we0    = ram_we0;
        last_we_any = ram_we0 | ram_we1;

        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        if (reset) begin
            m_rr = 0;
        end else begin
            if (p0 >= 0) serve(p0);
            if (p1 >= 0) serve(p1);
            if (p1 >= 0)      m_rr = (p1 + 1) % N;
            else if (p0 >= 0) m_rr = (p0 + 1) % N;
        end

        @(posedge clk);
        #1;
        req = req & ~eg;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        m_rr        = 0;
        reset       = 1'b1;
        ram_init    = 1'b1;
        req         = '0;
        req_we      = '0;
        req_address = '0;
        req_data    = '0;
        for (int k = 0; k < 16; k++) m_mem[k] = 32'hA0 + k;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
        end

        @(posedge clk);
        #1;
        cycle();
        cycle();
        ram_init = 1'b0;
        reset    = 1'b0;

        // Reset state: nothing pending, nothing granted
        cycle();
        chk("rst_resp_valid", 64'(last_rv), 64'(0));
        chk("rst_grant", 64'(last_grant), 64'(0));

        // Single read by requester 0
        set_req(0, 1'b0, 5, 32'h0);
        cycle();
        chk("t1_grant", 64'(last_grant), 64'(4'b0001));
        cycle();
        chk("t1_resp_valid", 64'(last_rv), 64'(4'b0001));
        chk("t1_resp_data", 64'(last_rdata[31:0]), 64'(32'hA5));

        // Four reads of distinct addresses: rotation 0011, 1100, 0011
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int r = 0; r < N; r++) set_req(r, 1'b0, r + 1, 32'h0);
        cycle();
        chk("t2_grant_a", 64'(last_grant), 64'(4'b0011));
        cycle();
        chk("t2_grant_b", 64'(last_grant), 64'(4'b1100));
        for (int r = 0; r < N; r++) set_req(r, 1'b0, r + 1, 32'h0);
        cycle();
        chk("t2_grant_c", 64'(last_grant), 64'(4'b0011));
        drain(2);

        // Two writes to the same address are serialised
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_req(0, 1'b1, 7, 32'h11);
        set_req(1, 1'b1, 7, 32'h22);
        cycle();
        chk("t3_grant_a", 64'(last_grant), 64'(4'b0001));
        cycle();
        chk("t3_grant_b", 64'(last_grant), 64'(4'b0010));
        set_req(0, 1'b0, 7, 32'h0);
        cycle();
        cycle();
        chk("t3_read_back", 64'(last_rdata[31:0]), 64'(32'h22));

        // Read and write of the same address are serialised
        set_req(2, 1'b0, 3, 32'h0);
        set_req(3, 1'b1, 3, 32'h33);
        cycle();
        chk("t4_grant_a", 64'(last_grant), 64'(4'b0100));
        cycle();
        chk("t4_grant_b", 64'(last_grant), 64'(4'b1000));
        set_req(0, 1'b0, 3, 32'h0);
        cycle();
        cycle();
        chk("t4_read_back", 64'(last_rdata[31:0]), 64'(32'h33));

        // Reset right after a read grant drops the response
        set_req(1, 1'b0, 6, 32'h0);
        cycle();
        chk("t5_grant", 64'(last_grant), 64'(4'b0010));
        reset = 1'b1;
        set_req(0, 1'b1, 10, 32'hBAD0);
        set_req(1, 1'b0, 11, 32'h0);
        set_req(2, 1'b1, 12, 32'hBAD2);
        set_req(3, 1'b0, 13, 32'h0);
        cycle();
        chk("t5_resp_valid", 64'(last_rv), 64'(0));
        chk("t5_grant_rst", 64'(last_grant), 64'(0));
        chk("t5_we_rst", 64'(last_we_any), 64'(0));
        reset = 1'b0;
        cycle();
        chk("t5_grant_after", 64'(last_grant), 64'(4'b0011));
        drain(3);

        // Single write returns its data and lands in memory
        set_req(2, 1'b1, 9, 32'hDEAD);
        cycle();
        chk("t6_we0", 64'(last_we0), 64'(1));
        cycle();
        chk("t6_resp_valid", 64'(last_rv), 64'(4'b0100));
        chk("t6_resp_data", 64'(last_rdata[95:64]), 64'(32'hDEAD));
        set_req(0, 1'b0, 9, 32'h0);
        cycle();
        cycle();
        chk("t6_read_back", 64'(last_rdata[31:0]), 64'(32'hDEAD));

        // Random traffic over a small address range to provoke conflicts
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < N; r++) begin
                if (!req[r] && $urandom_range(0, 1) == 1) begin
                    set_req(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), DW'($urandom));
                end
            end
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;
        req   = '0;
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dual_port_ram_arbiter
`default_nettype wire
